// File: rtl/stream_capture_pkg.sv
// stream_capture_pkg
// Shared types and helpers for the stream capture buffer:
//   cap_state_t  - run-control states (IDLE, CAPTURE, FLUSH, DONE)
//   ptr_width()  - FIFO pointer width for a given depth (address bits + wrap bit)
package stream_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers only)
//   clear       - synchronous pointer clear; empties the FIFO
//   push        - write push_data this cycle (taken when not full or popping)
//   push_data   - word to write
//   pop         - read-advance this cycle (taken when not empty)
//   pop_data    - combinational read of the word at the read pointer
//   full, empty - occupancy flags
//   count       - current occupancy, 0..DEPTH
import stream_capture_pkg::*;

module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [ptr_width(DEPTH)-1:0]    count
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                    (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  // Pointer difference wraps modulo 2*DEPTH, giving 0..DEPTH directly.
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; contents are only visible while not empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/stream_capture_buffer.sv
// stream_capture_buffer
// Captures qualified input words into a FIFO during a run, drains them to a
// sink that may stall, and flushes the remainder when the run ends.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - pulse: begin a run (accepted in IDLE or DONE)
//   in_valid     - in_data is valid this cycle
//   in_data      - input word
//   done         - pulse: end capture and flush (accepted in CAPTURE only)
//   out_valid    - out_data holds a buffered word (FIFO not empty)
//   out_data     - head-of-FIFO word
//   out_ready    - sink accepts out_data this cycle
//   out_last     - out_data is the final word of the run (FLUSH, one word left)
//   busy         - run in progress (CAPTURE or FLUSH)
//   run_done     - run finished (DONE)
//   overflow     - sticky: a word was dropped this run
//   word_count   - words accepted this run, saturating
//   drop_count   - words dropped this run, saturating
//   state        - current run-control state, for observation
//
// Output handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and while
// out_ready is low out_valid and out_data hold stable.
import stream_capture_pkg::*;

module stream_capture_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  done,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  run_done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output cap_state_t            state
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W-1:0] fifo_count;
  logic             pop;
  logic             push;
  logic             drop;
  logic             start_run;

  assign pop       = out_valid && out_ready;
  assign push      = (state == ST_CAPTURE) && in_valid && (!fifo_full || pop);
  assign drop      = (state == ST_CAPTURE) && in_valid && fifo_full && !pop;
  assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_run),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = (state == ST_FLUSH) && (fifo_count == PTR_W'(1));
  assign busy      = (state == ST_CAPTURE) || (state == ST_FLUSH);
  assign run_done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (start_run) begin
      state      <= ST_CAPTURE;
      word_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (push && (word_count != '1)) word_count <= word_count + 1'b1;
          if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
          end
          if (done) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Empty on entry exits after one cycle; otherwise leave as the last word pops.
          if (fifo_empty || ((fifo_count == PTR_W'(1)) && pop)) state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_capture_buffer.sv
// tb_stream_capture_buffer
// Directed bench for stream_capture_buffer with DATA_WIDTH=8, DEPTH=4.
import stream_capture_pkg::*;

module tb_stream_capture_buffer;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          done = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          run_done;
  logic          overflow;
  logic [CW-1:0] word_count;
  logic [CW-1:0] drop_count;
  cap_state_t    state;

  stream_capture_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .done       (done),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .run_done   (run_done),
    .overflow   (overflow),
    .word_count (word_count),
    .drop_count (drop_count),
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_passed++;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    tick();
    tick();
    check("rst_out_valid",  out_valid,  0);
    check("rst_busy",       busy,       0);
    check("rst_run_done",   run_done,   0);
    check("rst_overflow",   overflow,   0);
    check("rst_word_count", word_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_out_last",   out_last,   0);
    check("rst_state",      state,      ST_IDLE);
    rst_n = 1'b1;
    tick();

    // done outside CAPTURE is ignored
    pulse_done();
    check("idle_done_ignored", state, ST_IDLE);

    // Basic pass-through
    pulse_start();
    check("start_state", state, ST_CAPTURE);
    check("start_busy",  busy,  1);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      exp_q.push_back(DW'(i));
      tick();
      check("pt_valid", out_valid, 1);
      check("pt_data",  out_data,  exp_q.pop_front());
    end
    in_valid = 1'b0;
    tick();
    check("pt_drained",    out_valid,  0);
    check("pt_word_count", word_count, 3);
    check("pt_drop_count", drop_count, 0);

    // Back-pressure and overflow: 4 stored, 2 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    check("bp_count",      dut.u_fifo.count, 4);
    check("bp_drop_count", drop_count, 2);
    check("bp_overflow",   overflow,   1);
    check("bp_word_count", word_count, 7);
    check("bp_head",       out_data,   8'h10);
    tick();
    check("stall_valid", out_valid, 1);
    check("stall_data",  out_data,  8'h10);

    // Push on full with simultaneous pop
    in_valid  = 1'b1;
    in_data   = 8'h20;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fullpop_count",      dut.u_fifo.count, 4);
    check("fullpop_drop_count", drop_count, 2);
    check("fullpop_word_count", word_count, 8);
    check("fullpop_head",       out_data,   8'h11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_one_head",  out_data, 8'h12);
    check("pop_one_count", dut.u_fifo.count, 3);

    // Flush with 3 words; inputs and start are ignored during FLUSH
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h20);
    pulse_done();
    check("flush_state",    state,    ST_FLUSH);
    check("flush_busy",     busy,     1);
    in_valid  = 1'b1;
    in_data   = 8'h99;
    start     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("flush_valid", out_valid, 1);
      check("flush_data",  out_data,  exp_q.pop_front());
      check("flush_last",  out_last,  (k == 2) ? 1 : 0);
      check("flush_hold",  state,     ST_FLUSH);
      tick();
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    check("flush_run_done",   run_done,   1);
    check("flush_busy_off",   busy,       0);
    check("flush_empty",      out_valid,  0);
    check("flush_last_off",   out_last,   0);
    check("flush_word_count", word_count, 8);

    // start in DONE clears counters
    pulse_start();
    check("restart_state",    state,      ST_CAPTURE);
    check("restart_busy",     busy,       1);
    check("restart_run_done", run_done,   0);
    check("restart_words",    word_count, 0);
    check("restart_drops",    drop_count, 0);
    check("restart_overflow", overflow,   0);

    // start during CAPTURE has no effect
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h30;
    tick();
    in_data  = 8'h31;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("cap_start_words", word_count, 2);
    check("cap_start_state", state, ST_CAPTURE);
    check("cap_start_count", dut.u_fifo.count, 2);
    check("cap_start_head",  out_data, 8'h30);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("cap_drained", out_valid, 0);

    // done with an empty FIFO: DONE after one cycle, no out_last
    pulse_done();
    check("empty_flush_state", state,    ST_FLUSH);
    check("empty_flush_last",  out_last, 0);
    tick();
    check("empty_done_state",  state,    ST_DONE);
    check("empty_done_flag",   run_done, 1);
    check("empty_done_last",   out_last, 0);

    // Reset mid-FLUSH with 2 words buffered
    pulse_start();
    in_valid = 1'b1;
    in_data  = 8'h40;
    tick();
    in_data  = 8'h41;
    tick();
    in_valid = 1'b0;
    pulse_done();
    check("mid_state", state, ST_FLUSH);
    check("mid_count", dut.u_fifo.count, 2);
    rst_n = 1'b0;
    #1;
    check("mrst_state",      state,      ST_IDLE);
    check("mrst_out_valid",  out_valid,  0);
    check("mrst_out_last",   out_last,   0);
    check("mrst_busy",       busy,       0);
    check("mrst_run_done",   run_done,   0);
    check("mrst_overflow",   overflow,   0);
    check("mrst_word_count", word_count, 0);
    check("mrst_drop_count", drop_count, 0);
    check("mrst_count",      dut.u_fifo.count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", state,     ST_IDLE);
    check("post_rst_valid", out_valid, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_capture_buffer.md
# stream_capture_buffer

Parametrised capture buffer between a stream source (e.g. `file_reader`) and a sink that can stall (e.g. `file_writer`). Captures qualified data words into an internal FIFO, drains them over a valid/ready handshake, and handles end-of-run flushing through a `done` request. It counts accepted and dropped words. It succeeds the fixed-width, free-running reader-to-writer path, adding back-pressure, buffering and run control.

## Interface
- `DATA_WIDTH`, 8: width of a data word in bits.
- `DEPTH`, 16: FIFO depth in words; must be a power of two and at least 2.
- `CNT_WIDTH`, 16: width of the word and drop counters.

Clock and reset are fixed: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a capture run.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_data` in DATA_WIDTH: input word.
- `done` in 1: one-cycle pulse that ends capture and requests a flush.
- `out_valid` out 1: `out_data` holds a buffered word.
- `out_data` out DATA_WIDTH: head-of-FIFO word.
- `out_ready` in 1: the sink accepts the word this cycle.
- `out_last` out 1: the current `out_data` is the final word of the run.
- `busy` out 1: high in CAPTURE or FLUSH.
- `run_done` out 1: high in DONE.
- `overflow` out 1: sticky; set when a word has been dropped this run.
- `word_count` out CNT_WIDTH: words accepted this run; saturates.
- `drop_count` out CNT_WIDTH: words dropped this run; saturates.

## Operation
**States:** IDLE, CAPTURE, FLUSH, DONE. Reset enters IDLE.
- **IDLE.** `start` moves to CAPTURE.
- **Entering CAPTURE.** Clears the FIFO pointers, `word_count`, `drop_count` and `overflow`.
- **Push rule.** In CAPTURE, a word is pushed when `in_valid` is high and either the FIFO is not full or a pop occurs in the same cycle.
- **Drop rule.** When `in_valid` is high, the FIFO is full and there is no pop, the word is dropped. `drop_count` increments and `overflow` sets.
- **CAPTURE to FLUSH.** `done` moves to FLUSH. An `in_valid` word in the same cycle as `done` is still subject to the push rule. Inputs are ignored from FLUSH onward.
- **FLUSH.** Drains the FIFO. Moves to DONE on the cycle its last word pops. If the FIFO is already empty on entry, moves to DONE after one cycle and emits no `out_last`.
- **DONE.** `start` begins a new run and applies the same clears as entering CAPTURE.
- **Ignored strobes.** `start` is ignored in CAPTURE and FLUSH. `done` is ignored outside CAPTURE.
- **Pop rule.** A pop occurs when `out_valid` and `out_ready` are both high. A pop is allowed in any state.
- **FIFO behaviour.** First-word-fall-through. `out_valid` equals not-empty. `out_data` is a combinational read of the memory at `rd_ptr`.
- **Pointer arithmetic.** Pointers are log2(DEPTH)+1 bits wide. Full is when the addresses are equal and the wrap bits differ. Empty is when the pointers are equal. Wrap-around is modulo 2·DEPTH.
- **out_last.** Equals (state==FLUSH) && (occupancy==1).
- **Counter saturation.** `word_count` and `drop_count` saturate at 2^CNT_WIDTH−1.

## Timing
- **Reset values.** All outputs are 0, the state is IDLE and the FIFO is empty. `out_data` reads memory contents and is don't-care while `out_valid` is 0.
- **Reset mid-operation.** Reset mid-run returns to IDLE immediately. Buffered data is discarded.
- **Input-to-output latency.** A word pushed at rising edge N gives `out_valid` high after edge N, i.e. in cycle N+1.
- **State-change latency.** A `start` or `done` sampled at edge N changes the state after edge N. The flags `busy` and `run_done` are decoded from the registered state and carry no further lag.
- **Counter update.** Counters and `overflow` update at the same edge as the push or drop that causes them.
- **Stall hold.** While `out_ready` is low, `out_data` and `out_valid` hold stable.
- **Throughput.** Sustained rate is one word per cycle with `out_ready` tied high. Occupancy never exceeds DEPTH.

## Structure
- **Package `stream_capture_pkg`.** Holds the state enum `cap_state_t` (IDLE, CAPTURE, FLUSH, DONE) and the localparam helper for pointer width, $clog2(DEPTH)+1.
- **Sub-module `sync_fifo`.** Parametrised by DATA_WIDTH and DEPTH, with ports push, pop, full, empty and count. It is single-clock and shares `rst_n`.
- **Top level.** Holds the FSM, the push/drop decision, the counters and `out_last`.

## Test plan
- **Basic pass-through.** DATA_WIDTH=8, DEPTH=4. Stimulus: `start`, then push 0x01..0x03 with `out_ready`=1. Required: each word on `out_data` one cycle later, `word_count`=3, `drop_count`=0.
- **Back-pressure and overflow.** Stimulus: `out_ready`=0, push 6 words 0x10..0x15. Required: 0x10..0x13 stored, 2 dropped, `overflow`=1, `drop_count`=2. Then raise `out_ready`: required output order is 0x10..0x13.
- **Push on full with simultaneous pop.** Stimulus: FIFO full, `in_valid` and a pop in the same cycle. Required: word accepted, occupancy stays 4, no drop.
- **Flush and last.** Stimulus: 3 words buffered, `done` pulse, `out_ready`=1. Required: state FLUSH, `out_last` high only with the third word, `run_done`=1 on the following cycle.
- **Boundary strobes.** Stimulus: `done` with an empty FIFO. Required: DONE after one cycle, no `out_last`. Then `start` in DONE: required counters cleared and `busy`=1. `start` during CAPTURE: required to have no effect.
- **Reset mid-run.** Stimulus: deassert `rst_n` mid-FLUSH with 2 words buffered. Required: all outputs 0 immediately, IDLE, FIFO empty.
